// File: rtl/uc_booth4_if.sv
// uc_booth4_if: handshake and control bundle between the radix-4 Booth
// control unit and its datapath / host system.
//   Inicio            start request from the host
//   q1, q0, q_menos1  multiplier LSBs and Q[-1] from the datapath
//   Carga_A           load adder/subtractor result into A
//   Carga_QM          load multiplicand into M/M2 and multiplier into Q
//   Desplaza_AQ       arithmetic shift of A:Q right by 2, update Q[-1]
//   MoM2              operand select: 0 = M, 1 = 2M
//   Resta             1 = subtract, 0 = add
//   Limpia            datapath clear request
//   Ocupado           operation in progress
//   Fin               one-cycle result-valid pulse
// modport master: the control unit; modport slave: datapath/host side.
interface uc_booth4_if;
  logic Inicio;
  logic q1;
  logic q0;
  logic q_menos1;
  logic Carga_A;
  logic Carga_QM;
  logic Desplaza_AQ;
  logic MoM2;
  logic Resta;
  logic Limpia;
  logic Ocupado;
  logic Fin;

  modport master (
    input  Inicio, q1, q0, q_menos1,
    output Carga_A, Carga_QM, Desplaza_AQ, MoM2, Resta, Limpia, Ocupado, Fin
  );

  modport slave (
    output Inicio, q1, q0, q_menos1,
    input  Carga_A, Carga_QM, Desplaza_AQ, MoM2, Resta, Limpia, Ocupado, Fin
  );
endinterface

// File: rtl/uc_booth4.sv
// uc_booth4: control unit for the radix-4 (modified) Booth multiplier
// datapath. Sequences clear, load, SIZE/2 evaluate/shift iterations and a
// one-cycle done pulse.
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    uc_booth4_if.master (Inicio/q inputs, datapath control outputs)
// SIZE: operand width, even and >= 2.
module uc_booth4 #(
  parameter int unsigned SIZE = 4
) (
  input  logic         clk,
  input  logic         reset,
  uc_booth4_if.master  bus
);

  localparam int unsigned CW = $clog2(SIZE / 2) + 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    EVAL,
    SHIFT,
    DONE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next      = state;
    count_next      = count;
    bus.Carga_A     = 1'b0;
    bus.Carga_QM    = 1'b0;
    bus.Desplaza_AQ = 1'b0;
    bus.MoM2        = 1'b0;
    bus.Resta       = 1'b0;
    bus.Limpia      = 1'b0;
    bus.Ocupado     = 1'b0;
    bus.Fin         = 1'b0;

    case (state)
      IDLE: begin
        if (bus.Inicio) state_next = CLEAR;
      end
      CLEAR: begin
        bus.Limpia  = 1'b1;
        bus.Ocupado = 1'b1;
        state_next  = LOAD;
      end
      LOAD: begin
        bus.Carga_QM = 1'b1;
        bus.Ocupado  = 1'b1;
        count_next   = CW'(SIZE / 2 - 1);
        state_next   = EVAL;
      end
      EVAL: begin
        bus.Ocupado = 1'b1;
        state_next  = SHIFT;
        // Booth radix-4 recoding of {Q[1], Q[0], Q[-1]}
        case ({bus.q1, bus.q0, bus.q_menos1})
          3'b001, 3'b010: begin
            bus.Carga_A = 1'b1;
          end
          3'b011: begin
            bus.Carga_A = 1'b1;
            bus.MoM2    = 1'b1;
          end
          3'b100: begin
            bus.Carga_A = 1'b1;
            bus.MoM2    = 1'b1;
            bus.Resta   = 1'b1;
          end
          3'b101, 3'b110: begin
            bus.Carga_A = 1'b1;
            bus.Resta   = 1'b1;
          end
          default: ;
        endcase
      end
      SHIFT: begin
        bus.Desplaza_AQ = 1'b1;
        bus.Ocupado     = 1'b1;
        if (count != '0) begin
          count_next = count - CW'(1);
          state_next = EVAL;
        end else begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus.Fin     = 1'b1;
        bus.Ocupado = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uc_booth4.sv
// tb_uc_booth4: directed self-checking bench for uc_booth4 (SIZE=4) paired
// with a behavioural radix-4 Booth datapath; datapath reset = reset | Limpia.
module tb_uc_booth4;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  uc_booth4_if bus ();

  uc_booth4 #(.SIZE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural datapath
  logic [3:0]        mcand;
  logic [3:0]        mplier;
  logic signed [5:0] acc;
  logic [3:0]        q_reg;
  logic              qm1;
  logic [3:0]        m_reg;
  logic signed [5:0] m_ext;
  logic signed [5:0] opnd;
  logic [7:0]        product;
  logic [7:0]        outs;

  assign m_ext   = {{2{m_reg[3]}}, m_reg};
  assign opnd    = bus.MoM2 ? (m_ext <<< 1) : m_ext;
  assign product = {acc[3:0], q_reg};
  assign bus.q1       = q_reg[1];
  assign bus.q0       = q_reg[0];
  assign bus.q_menos1 = qm1;
  assign outs = {bus.Limpia, bus.Carga_QM, bus.Carga_A, bus.Desplaza_AQ,
                 bus.MoM2, bus.Resta, bus.Ocupado, bus.Fin};

  always_ff @(posedge clk) begin
    if (reset || bus.Limpia) begin
      acc   <= '0;
      q_reg <= '0;
      qm1   <= 1'b0;
      m_reg <= '0;
    end else begin
      if (bus.Carga_QM) begin
        m_reg <= mcand;
        q_reg <= mplier;
      end
      if (bus.Carga_A) acc <= bus.Resta ? acc - opnd : acc + opnd;
      if (bus.Desplaza_AQ) begin
        acc   <= acc >>> 2;
        q_reg <= {acc[1:0], q_reg[3:2]};
        qm1   <= q_reg[1];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation, observed for 14 cycles after the start edge.
  // Cycle c = state after the c-th edge following Inicio (c=1 is CLEAR).
  task automatic run_op(input logic [3:0] mc, input logic [3:0] mp, input bit poke,
                        output logic [7:0] res, output int lat, output int nfin,
                        output int busy, output logic [2:0] ev1,
                        output logic [2:0] ev2, output int clash);
    int loads;
    mcand = mc;
    mplier = mp;
    res = '0;
    lat = 0;
    nfin = 0;
    busy = 0;
    clash = 0;
    ev1 = '0;
    ev2 = '0;
    bus.Inicio = 1'b1;
    @(posedge clk); #1;
    bus.Inicio = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (bus.Ocupado) busy++;
      if (bus.Fin) begin
        nfin++;
        if (lat == 0) begin
          lat = c;
          res = product;
        end
      end
      if (c == 3) ev1 = {bus.Carga_A, bus.MoM2, bus.Resta};
      if (c == 5) ev2 = {bus.Carga_A, bus.MoM2, bus.Resta};
      loads = int'(bus.Limpia) + int'(bus.Carga_QM) + int'(bus.Carga_A) + int'(bus.Desplaza_AQ);
      if (loads > 1) clash++;
      if (poke) bus.Inicio = (c == 3);
      @(posedge clk); #1;
    end
    bus.Inicio = 1'b0;
  endtask

  logic [7:0] res;
  int         lat, nfin, busy, clash, nf, idle_cnt, fin_cnt, busy_cnt;
  logic [2:0] ev1, ev2;
  int         fin_at [3];
  logic [7:0] fin_res [3];

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    bus.Inicio = 1'b0;
    mcand = '0;
    mplier = '0;

    // reset and idle
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", 32'(outs), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("idle_outs", 32'(outs), 32'h0);
    end

    // 3 x 5
    run_op(4'd3, 4'd5, 1'b0, res, lat, nfin, busy, ev1, ev2, clash);
    check("p35_result", 32'(res), 32'h0F);
    check("p35_latency", 32'(lat), 32'd7);
    check("p35_fin_once", 32'(nfin), 32'd1);
    check("p35_busy_cycles", 32'(busy), 32'd7);
    check("p35_ev1_plusM", 32'(ev1), 32'b100);
    check("p35_clash", 32'(clash), 32'd0);

    // -8 x -8
    run_op(4'b1000, 4'b1000, 1'b0, res, lat, nfin, busy, ev1, ev2, clash);
    check("m8m8_result", 32'(res), 32'h40);
    check("m8m8_ev1_000", 32'(ev1), 32'b000);
    check("m8m8_ev2_100", 32'(ev2), 32'b111);
    check("m8m8_latency", 32'(lat), 32'd7);

    // -8 x 7
    run_op(4'b1000, 4'd7, 1'b0, res, lat, nfin, busy, ev1, ev2, clash);
    check("m8p7_result", 32'(res), 32'hC8);
    check("m8p7_ev1_110", 32'(ev1), 32'b101);
    check("m8p7_ev2_011", 32'(ev2), 32'b110);
    check("m8p7_clash", 32'(clash), 32'd0);

    // 3 x -1 exercises the 111 code; Inicio poked while busy
    run_op(4'd3, 4'b1111, 1'b1, res, lat, nfin, busy, ev1, ev2, clash);
    check("p3m1_result", 32'(res), 32'hFD);
    check("p3m1_ev2_111", 32'(ev2), 32'b000);
    check("poke_latency", 32'(lat), 32'd7);
    check("poke_busy_cycles", 32'(busy), 32'd7);
    check("poke_fin_once", 32'(nfin), 32'd1);

    // Inicio held for 20 edges: 2 x -3 back to back
    mcand = 4'd2;
    mplier = 4'b1101;
    nf = 0;
    idle_cnt = 0;
    bus.Inicio = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      @(posedge clk); #1;
      if (c == 20) bus.Inicio = 1'b0;
      if (bus.Fin && nf < 3) begin
        fin_at[nf] = c;
        fin_res[nf] = product;
        nf++;
      end else if (bus.Fin) begin
        nf++;
      end
      if (c <= 23 && !bus.Ocupado) idle_cnt++;
    end
    check("held_fin_count", 32'(nf), 32'd3);
    check("held_fin0_at", 32'(fin_at[0]), 32'd7);
    check("held_fin1_at", 32'(fin_at[1]), 32'd15);
    check("held_fin2_at", 32'(fin_at[2]), 32'd23);
    check("held_res0", 32'(fin_res[0]), 32'hFA);
    check("held_res1", 32'(fin_res[1]), 32'hFA);
    check("held_res2", 32'(fin_res[2]), 32'hFA);
    check("held_idle_cycles", 32'(idle_cnt), 32'd2);

    // reset during the second SHIFT
    mcand = 4'd3;
    mplier = 4'd5;
    bus.Inicio = 1'b1;
    @(posedge clk); #1;
    bus.Inicio = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_at_shift2", 32'(bus.Desplaza_AQ), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_outs", 32'(outs), 32'h0);
    fin_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.Fin) fin_cnt++;
      if (bus.Ocupado) busy_cnt++;
    end
    check("rst_no_fin", 32'(fin_cnt), 32'd0);
    check("rst_stays_idle", 32'(busy_cnt), 32'd0);

    run_op(4'd3, 4'd5, 1'b0, res, lat, nfin, busy, ev1, ev2, clash);
    check("after_rst_result", 32'(res), 32'h0F);
    check("after_rst_latency", 32'(lat), 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
